// File: rtl/mfp_uart_tx.sv
// mfp_uart_tx: FIFO-buffered UART transmitter, 8N1 frames, LSB first.
// Define MFP_UART_TX_PARITY_EN for 8E1 frames (even parity bit).
module mfp_uart_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          tx
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef MFP_UART_TX_PARITY_EN
    S_PAR   = 3'd3,
`endif
    S_STOP  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      head;
  logic            push, pop, tick;
`ifdef MFP_UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (level == (AW+1)'(FIFO_DEPTH));
  assign push  = wr_en && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign tick  = (cnt_q == '0);
  assign busy  = busy_q;
  assign tx    = tx_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef MFP_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) cnt_d = tick ? LOAD : cnt_q - 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
`ifdef MFP_UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PAR;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef MFP_UART_TX_PARITY_EN
      S_PAR: begin
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) begin
          // back-to-back frames: pop straight into the next start bit
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef MFP_UART_TX_PARITY_EN
    if (pop) par_d = ^head;
`endif
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef MFP_UART_TX_PARITY_EN
      S_PAR:   tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef MFP_UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_mfp_uart_tx.sv
// tb_mfp_uart_tx: directed bench for mfp_uart_tx at DIV=10.
// Frames are captured at bit centres and compared with expected frames.
module tb_mfp_uart_tx;
  localparam int DIV = 10;
`ifdef MFP_UART_TX_PARITY_EN
  localparam int FRAME = 11 * DIV;
  localparam int NB    = 11;
`else
  localparam int FRAME = 10 * DIV;
  localparam int NB    = 10;
`endif

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       busy;
  logic       tx;

  mfp_uart_tx #(
    .CLK_HZ    (1000),
    .BAUD      (100),
    .FIFO_DEPTH(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .full   (full),
    .empty  (empty),
    .level  (level),
    .busy   (busy),
    .tx     (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic [10:0] f8n1;
    logic [10:0] f8e1;
  } vec_t;

  int n_run  = 0;
  int n_fail = 0;
  logic [10:0] rxq[$];
  logic [10:0] mf;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b);
`ifdef MFP_UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  function automatic logic [10:0] exp_of(input vec_t v);
`ifdef MFP_UART_TX_PARITY_EN
    return v.f8e1;
`else
    return v.f8n1;
`endif
  endfunction

  // line receiver: start edge, then one sample per bit centre
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        mf = '0;
        repeat (DIV/2) @(negedge clk);
        mf[0] = tx;
        for (int j = 1; j < NB; j++) begin
          repeat (DIV) @(negedge clk);
          mf[j] = tx;
        end
        rxq.push_back(mf);
      end
    end
  end

  task automatic put(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((busy || !empty) && k < 20*FRAME) begin
      @(negedge clk);
      k++;
    end
    chk("drain_done", {31'd0, busy | ~empty}, 32'd0);
    repeat (5) @(negedge clk);
  endtask

  vec_t tv[5];
  vec_t b2[3];
  int   n, k, j, gaps;

  initial begin
    tv[0] = '{8'hA5, 11'h34A, 11'h54A};
    tv[1] = '{8'h07, 11'h20E, 11'h60E};
    tv[2] = '{8'h03, 11'h206, 11'h406};
    tv[3] = '{8'h81, 11'h302, 11'h502};
    tv[4] = '{8'h00, 11'h200, 11'h400};
    b2[0] = '{8'h00, 11'h200, 11'h400};
    b2[1] = '{8'hFF, 11'h3FE, 11'h5FE};
    b2[2] = '{8'h3C, 11'h278, 11'h478};

    rst = 1'b1; wr_en = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      rxq.delete();
      put(tv[i].d);
      chk("lat_e0", {31'd0, tx}, 32'd1);
      @(negedge clk);
      chk("lat_e1", {31'd0, tx}, 32'd0);
      n = 0;
      while (busy === 1'b1 && n < 2*FRAME) begin
        n++;
        @(negedge clk);
      end
      chk("busy_len", n, FRAME);
      repeat (5) @(negedge clk);
      chk("rx_cnt", rxq.size(), 1);
      if (rxq.size() > 0) chk("frame", {21'd0, rxq[0]}, {21'd0, exp_of(tv[i])});
    end

    rxq.delete();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = b2[i].d;
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("b2b_level", {27'd0, level}, 32'd2);
    k = 0; gaps = 0;
    while (!empty && k < 4*FRAME) begin
      @(negedge clk);
      k++;
      if (!busy) gaps++;
    end
    chk("b2b_empty_rise", k, 2*FRAME-1);
    j = 0;
    while (busy && j < 2*FRAME) begin
      @(negedge clk);
      j++;
    end
    chk("b2b_busy_tail", j, FRAME);
    chk("b2b_gaps", gaps, 0);
    repeat (5) @(negedge clk);
    chk("b2b_cnt", rxq.size(), 3);
    for (int i = 0; i < 3 && i < rxq.size(); i++)
      chk("b2b_frame", {21'd0, rxq[i]}, {21'd0, exp_of(b2[i])});

    rxq.delete();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      @(negedge clk);
      chk("fill_level", {27'd0, level}, (i == 0) ? 32'd1 : 32'(i));
      chk("fill_full", {31'd0, full}, (i == 16) ? 32'd1 : 32'd0);
    end
    wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    chk("drop_level", {27'd0, level}, 32'd16);
    chk("drop_full", {31'd0, full}, 32'd1);
    repeat (FRAME-17) @(negedge clk);
    chk("prepop_level", {27'd0, level}, 32'd16);
    put(8'hDD);
    chk("poppush_full_level", {27'd0, level}, 32'd15);
    chk("poppush_full_full", {31'd0, full}, 32'd0);
    drain();
    chk("fill_rx_cnt", rxq.size(), 17);
    for (int i = 0; i < 17 && i < rxq.size(); i++)
      chk("fill_order", {21'd0, rxq[i]}, {21'd0, mkframe(8'(8'h10 + i))});

    rxq.delete();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("l5_level", {27'd0, level}, 32'd5);
    repeat (FRAME-5) @(negedge clk);
    chk("l5_prepop", {27'd0, level}, 32'd5);
    put(8'h77);
    chk("l5_poppush", {27'd0, level}, 32'd5);
    drain();
    chk("l5_rx_cnt", rxq.size(), 7);
    for (int i = 0; i < 7 && i < rxq.size(); i++)
      chk("l5_order", {21'd0, rxq[i]},
          {21'd0, mkframe((i == 6) ? 8'h77 : 8'(8'h40 + i))});

    wr_en = 1'b1; wr_data = 8'h81;
    @(negedge clk);
    wr_data = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (28) @(negedge clk);
    chk("mid_tx", {31'd0, tx}, 32'd0);
    chk("mid_level", {27'd0, level}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_tx", {31'd0, tx}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_level", {27'd0, level}, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (2*FRAME) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) n++;
    end
    chk("post_rst_quiet", n, 0);
    rxq.delete();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
